al_accel_pe_row: RTL and testbench
==================================

// Module: al_accel_pe_row
// PURPOSE
// 3-tap signed int8 convolution row engine. Sits directly downstream of the weight buffer:
// consumes its three weight taps (do_0/1/2) and an activation stream, produces one
// partial sum per valid window position. Adds an incoming partial sum, so rows of a 3x3 kernel chain.
// PARAMETERS
// DW     8   activation/weight width, signed two's complement
// AW     32  partial-sum / output width
// LENW   10  width of row length and counters
// PORTS
// clk        in   1     clock, rising edge
// resetn     in   1     asynchronous active-low reset
// enb        in   1     global enable; 0 freezes all state, outputs held
// start      in   1     pulse: begin a row; ignored unless state IDLE
// row_len    in   LENW  activations in row; sampled on accepted start
// w0,w1,w2   in   DW    weight taps from weight buffer; latched on accepted start
// act_valid  in   1     activation handshake valid
// act_ready  out  1     activation handshake ready
// act_data   in   DW    activation sample
// psum_in    in   AW    partial sum, sampled with the activation completing a window
// out_valid  out  1     result valid
// out_ready  in   1     result ready
// out_data   out  AW    result
// busy       out  1     state != IDLE
// done       out  1     one-cycle pulse, row complete
// BEHAVIOUR
// - Reset: state IDLE, act_ready=0, out_valid=0, out_data=0, done=0, busy=0, all windows/counters 0.
// - FSM: IDLE -start&enb-> FILL (row_len>=3) or DONE (row_len<3, no outputs); FILL: accept a[0],a[1]
//   -> RUN; RUN: each accept fills window, pushes one pipeline entry; after in_cnt==row_len -> FLUSH;
//   FLUSH: wait pipeline empty and last out handshake -> DONE; DONE: done=1 one cycle -> IDLE.
// - Weights latched at start so the weight buffer may shift/reload during the row.
// - y[i] = w0*a[i] + w1*a[i+1] + w2*a[i+2] + psum_in[i], i = 0..row_len-3; psum_in[i] paired with a[i+2].
// - Arithmetic: products DW x DW signed -> 2*DW; sum sign-extended to AW, wraps modulo 2^AW.
// - Pipeline: S1 registers three products + psum; S2 registers sum into out_data. Latency: 2 cycles
//   from act accept (window complete) to out_valid. Throughput 1/cycle.
// - adv = enb & (!out_valid | out_ready); whole pipeline stalls when !adv (no bubble collapse).
// - act_ready = adv & state in {FILL,RUN} & in_cnt<row_len. Accept = act_valid & act_ready.
// - out_valid/out_data stable while out_valid & !out_ready. Exactly row_len-2 outputs per row.
// - start during busy ignored; start and enb=0 same cycle ignored.
// - Async reset mid-row aborts: no done, no further outputs, weights cleared.
// - row_len=0..2: IDLE -> DONE -> IDLE, done pulses 2 cycles after start, out_valid never asserts.
// CONFIGURATION
// AL_ACCEL_PE_RELU_EN defined: S2 result clamped to 0 if negative (sign bit set) before out_data.
// Not defined: raw wrapped sum passed; no comparator logic synthesized.
// STRUCTURE
// al_accel_pkg: FSM state enum (IDLE,FILL,RUN,FLUSH,DONE), DW/AW/LENW default localparams.
// Sub-module al_accel_mac3: 3-product + psum two-stage pipeline with adv stall input, RELU option.
// Top holds FSM, activation window, in/out counters, handshake logic.
// TESTING
// - Reset mid-RUN: resetn=0 async -> out_valid, act_ready, busy drop immediately; no done.
// - w=(1,2,3), row_len=5, a=1..5, psum=0, out_ready=1 -> outputs 14,20,26; done 1 cycle after last.
// - w=(-128,-128,-128), a=(-128 x3), psum=0x7FFFFFFF -> wraps to 0x8000BFFF; RELU_EN -> 0 output.
// - out_ready held 0 for 5 cycles mid-row -> out_data stable, act_ready=0, no loss/duplication.
// - row_len=2 -> zero outputs, done pulse; start while busy -> ignored, row completes unchanged.
// - Change w0..2 one cycle after start -> results use latched weights.

Source files
------------

// File: rtl/al_accel_pkg.sv
// Shared types and default sizes for the al_accel PE row engine.
package al_accel_pkg;

  localparam int DW_DEF   = 8;
  localparam int AW_DEF   = 32;
  localparam int LENW_DEF = 10;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    RUN,
    FLUSH,
    DONE
  } pe_state_t;

endpackage

// File: rtl/al_accel_mac3.sv
// Two-stage 3-tap signed MAC: S1 registers the three products plus psum, S2 registers the sum.
// Build option AL_ACCEL_PE_RELU_EN clamps negative sums to zero before the output register.
module al_accel_mac3
  import al_accel_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          adv,
  input  logic          in_valid,
  input  logic [DW-1:0] a0,
  input  logic [DW-1:0] a1,
  input  logic [DW-1:0] a2,
  input  logic [DW-1:0] w0,
  input  logic [DW-1:0] w1,
  input  logic [DW-1:0] w2,
  input  logic [AW-1:0] psum,
  output logic          pending,
  output logic          out_valid,
  output logic [AW-1:0] out_data
);

  logic [DW-1:0]   a_vec [3];
  logic [DW-1:0]   w_vec [3];
  logic [2*DW-1:0] prod_reg [3];
  logic [AW-1:0]   prod_ext [3];
  logic [AW-1:0]   psum_reg;
  logic            s1_valid_reg;
  logic [AW-1:0]   sum;
  logic [AW-1:0]   result;

  assign a_vec = '{a0, a1, a2};
  assign w_vec = '{w0, w1, w2};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_tap
      // Operands sign-extended to 2*DW so the low half of the product is the signed result.
      logic [2*DW-1:0] a_ext;
      logic [2*DW-1:0] w_ext;
      logic [2*DW-1:0] prod_next;
      assign a_ext     = {{DW{a_vec[gi][DW-1]}}, a_vec[gi]};
      assign w_ext     = {{DW{w_vec[gi][DW-1]}}, w_vec[gi]};
      assign prod_next = a_ext * w_ext;
      assign prod_ext[gi] = {{(AW-2*DW){prod_reg[gi][2*DW-1]}}, prod_reg[gi]};

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          prod_reg[gi] <= '0;
        end else if (adv && in_valid) begin
          prod_reg[gi] <= prod_next;
        end
      end
    end
  endgenerate

  assign sum = prod_ext[0] + prod_ext[1] + prod_ext[2] + psum_reg;

`ifdef AL_ACCEL_PE_RELU_EN
  assign result = sum[AW-1] ? '0 : sum;
`else
  assign result = sum;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid_reg <= 1'b0;
      psum_reg     <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
    end else if (adv) begin
      s1_valid_reg <= in_valid;
      out_valid    <= s1_valid_reg;
      if (in_valid) begin
        psum_reg <= psum;
      end
      if (s1_valid_reg) begin
        out_data <= result;
      end
    end
  end

  assign pending = s1_valid_reg;

endmodule

// File: rtl/al_accel_pe_row.sv
// 3-tap signed convolution row engine: FSM, activation window, input counter and handshakes.
// Optional ReLU on the result when AL_ACCEL_PE_RELU_EN is defined (handled in al_accel_mac3).
module al_accel_pe_row
  import al_accel_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int AW   = AW_DEF,
  parameter int LENW = LENW_DEF
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            enb,
  input  logic            start,
  input  logic [LENW-1:0] row_len,
  input  logic [DW-1:0]   w0,
  input  logic [DW-1:0]   w1,
  input  logic [DW-1:0]   w2,
  input  logic            act_valid,
  output logic            act_ready,
  input  logic [DW-1:0]   act_data,
  input  logic [AW-1:0]   psum_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [AW-1:0]   out_data,
  output logic            busy,
  output logic            done
);

  pe_state_t       state_reg, state_next;
  logic [LENW-1:0] row_len_reg;
  logic [LENW-1:0] in_cnt_reg;
  logic [DW-1:0]   w0_reg, w1_reg, w2_reg;
  logic [DW-1:0]   a0_reg, a1_reg;
  logic            adv;
  logic            accept;
  logic            start_acc;
  logic            push;
  logic            pending;

  // The whole pipeline moves together; a held output stalls everything behind it.
  assign adv       = enb && (!out_valid || out_ready);
  assign start_acc = start && enb && (state_reg == IDLE);
  assign accept    = act_valid && act_ready;
  assign push      = accept && (state_reg == RUN);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    act_ready  = adv && ((state_reg == FILL) || (state_reg == RUN)) && (in_cnt_reg < row_len_reg);
    busy       = (state_reg != IDLE);
    done       = (state_reg == DONE);
    case (state_reg)
      IDLE: begin
        if (start && enb) begin
          state_next = (row_len >= LENW'(3)) ? FILL : DONE;
        end
      end
      FILL: begin
        if (accept && (in_cnt_reg == LENW'(1))) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (accept && (in_cnt_reg == row_len_reg - LENW'(1))) begin
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        if (enb && !pending && (!out_valid || out_ready)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (enb) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Weights are captured at start so the weight buffer is free to reload during the row.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      row_len_reg <= '0;
      in_cnt_reg  <= '0;
      w0_reg      <= '0;
      w1_reg      <= '0;
      w2_reg      <= '0;
      a0_reg      <= '0;
      a1_reg      <= '0;
    end else if (enb) begin
      if (start_acc) begin
        row_len_reg <= row_len;
        in_cnt_reg  <= '0;
        w0_reg      <= w0;
        w1_reg      <= w1;
        w2_reg      <= w2;
      end else if (accept) begin
        in_cnt_reg <= in_cnt_reg + LENW'(1);
        a0_reg     <= a1_reg;
        a1_reg     <= act_data;
      end
    end
  end

  al_accel_mac3 #(
    .DW(DW),
    .AW(AW)
  ) u_mac3 (
    .clk      (clk),
    .resetn   (resetn),
    .adv      (adv),
    .in_valid (push),
    .a0       (a0_reg),
    .a1       (a1_reg),
    .a2       (act_data),
    .w0       (w0_reg),
    .w1       (w1_reg),
    .w2       (w2_reg),
    .psum     (psum_in),
    .pending  (pending),
    .out_valid(out_valid),
    .out_data (out_data)
  );

endmodule

// File: tb/tb_al_accel_pe_row.sv
// Scoreboard bench for al_accel_pe_row; expectations follow AL_ACCEL_PE_RELU_EN when defined.
module tb_al_accel_pe_row;

  logic        clk;
  logic        resetn;
  logic        enb;
  logic        start;
  logic [9:0]  row_len;
  logic [7:0]  w0, w1, w2;
  logic        act_valid;
  logic        act_ready;
  logic [7:0]  act_data;
  logic [31:0] psum_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  al_accel_pe_row dut (
    .clk      (clk),
    .resetn   (resetn),
    .enb      (enb),
    .start    (start),
    .row_len  (row_len),
    .w0       (w0),
    .w1       (w1),
    .w2       (w2),
    .act_valid(act_valid),
    .act_ready(act_ready),
    .act_data (act_data),
    .psum_in  (psum_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  function automatic logic [31:0] model_y(input int k0, k1, k2, x0, x1, x2, input int ps);
    int y;
    y = k0 * x0 + k1 * x1 + k2 * x2 + ps;
`ifdef AL_ACCEL_PE_RELU_EN
    if (y < 0) y = 0;
`endif
    return 32'(y);
  endfunction

  // mode 0: a=1..len, psum 0; mode 1: a=-128, psum 0x7FFFFFFF; mode 2: random data and gaps
  task automatic run_row(input int ww0, ww1, ww2, input int len, input int mode,
                         input int stall_at, input bit chg_w, input bit busy_start);
    int a[$];
    int p[$];
    int idx, nout, hs_cyc, stall_left, exp_n, cyc;
    bit seen_done, stalled, prev_hold;
    logic [31:0] prev_data;
    for (int i = 0; i < len; i++) begin
      case (mode)
        0: begin a.push_back(i + 1); p.push_back(0); end
        1: begin a.push_back(-128); p.push_back(32'h7FFF_FFFF); end
        default: begin
          a.push_back(int'($urandom_range(0, 255)) - 128);
          p.push_back(int'($urandom_range(0, 2000000)) - 1000000);
        end
      endcase
    end
    exp_n = (len >= 3) ? len - 2 : 0;
    @(negedge clk);
    w0 = 8'(ww0); w1 = 8'(ww1); w2 = 8'(ww2);
    row_len = 10'(len);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (chg_w) begin
      w0 = 8'h55; w1 = 8'hAA; w2 = 8'h0F;
    end
    idx = 0; nout = 0; hs_cyc = -1; stall_left = 0;
    seen_done = 0; stalled = 0; prev_hold = 0; prev_data = '0;
    for (cyc = 0; cyc < 400 && !seen_done; cyc++) begin
      act_valid = (idx < len) && (mode != 2 || $urandom_range(0, 3) != 0);
      act_data  = (idx < len) ? 8'(a[idx]) : 8'h00;
      psum_in   = (idx < len) ? 32'(p[idx]) : 32'h0;
      if (stall_at >= 0 && !stalled && nout == stall_at) begin
        stall_left = 5;
        stalled = 1;
      end
      out_ready = (stall_left == 0);
      if (busy_start && cyc == 3) begin
        start = 1'b1;
        row_len = 10'd7;
      end else begin
        start = 1'b0;
      end
      #1;
      if (cyc == 0) check_val("busy", 32'(busy), 32'd1);
      if (prev_hold) check_val("hold_data", out_data, prev_data);
      if (out_valid && !out_ready) check_val("stall_rdy", 32'(act_ready), 32'd0);
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      if (done) begin
        seen_done = 1;
        if (nout > 0) check_val("done_lat", 32'(cyc - hs_cyc), 32'd1);
      end
      if (act_valid && act_ready) begin
        if (idx >= 2) begin
          exp_q.push_back(model_y(ww0, ww1, ww2, a[idx-2], a[idx-1], a[idx], p[idx]));
        end
        idx++;
      end
      if (out_valid && out_ready) begin
        check_val("sb_avail", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check_val($sformatf("out[%0d]", nout), out_data, exp_q.pop_front());
        nout++;
        hs_cyc = cyc;
      end
      if (stall_left > 0) stall_left--;
      @(negedge clk);
    end
    act_valid = 1'b0;
    start = 1'b0;
    out_ready = 1'b1;
    #1;
    check_val("done_seen", 32'(seen_done), 32'd1);
    check_val("done_pulse", 32'(done), 32'd0);
    check_val("idle_busy", 32'(busy), 32'd0);
    check_val("n_out", 32'(nout), 32'(exp_n));
    check_val("sb_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    resetn = 1'b0; enb = 1'b1; start = 1'b0; row_len = '0;
    w0 = '0; w1 = '0; w2 = '0;
    act_valid = 1'b0; act_data = '0; psum_in = '0; out_ready = 1'b1;
    #12;
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_act_ready", 32'(act_ready), 32'd0);
    check_val("rst_out_data", out_data, 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    run_row(1, 2, 3, 5, 0, -1, 1'b0, 1'b0);
    run_row(-128, -128, -128, 3, 1, -1, 1'b0, 1'b0);
    run_row(int'($urandom_range(0, 255)) - 128, -77, 101, 12, 2, 3, 1'b0, 1'b0);
    run_row(1, 1, 1, 2, 0, -1, 1'b0, 1'b0);
    run_row(2, -1, 3, 8, 0, -1, 1'b0, 1'b1);
    run_row(3, -2, 5, 6, 2, -1, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a row
    @(negedge clk);
    w0 = 8'd1; w1 = 8'd1; w2 = 8'd1; row_len = 10'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    act_valid = 1'b1; act_data = 8'd4; out_ready = 1'b1;
    repeat (4) @(negedge clk);
    check_val("pre_rst_busy", 32'(busy), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check_val("arst_out_valid", 32'(out_valid), 32'd0);
    check_val("arst_act_ready", 32'(act_ready), 32'd0);
    check_val("arst_busy", 32'(busy), 32'd0);
    act_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 check_val("arst_no_done", 32'(done), 32'd0);
    end
    @(negedge clk);
    resetn = 1'b1;
    #1 check_val("post_rst_out_valid", 32'(out_valid), 32'd0);

    run_row(-5, 7, 2, 4, 2, -1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
